// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: per-channel programmable tick pulses and square waves,
// with a small sequencer that applies configuration writes and global phase-align one at a time.
module tick_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 25,
    parameter int DEFAULT_PERIOD = 24999999,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK,
    input  logic              RESETN,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_enable,
    input  logic              align,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ALIGN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              align_pend_q, align_pend_d;
    logic [CH_W-1:0]   cap_ch_q, cap_ch_d;
    logic [CNT_W-1:0]  cap_period_q, cap_period_d;
    logic              cap_en_q, cap_en_d;
    logic              align_req;

    // An align seen in the same cycle that enters ALIGN is absorbed; any other align is remembered.
    assign align_req = align | align_pend_q;

    always_comb begin
        state_d      = state_q;
        align_pend_d = align_pend_q | align;
        cap_ch_d     = cap_ch_q;
        cap_period_d = cap_period_q;
        cap_en_d     = cap_en_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d      = ST_APPLY;
                    cap_ch_d     = cfg_ch;
                    cap_period_d = cfg_period;
                    cap_en_d     = cfg_enable;
                end else if (align_req) begin
                    state_d      = ST_ALIGN;
                    align_pend_d = 1'b0;
                end
            end
            ST_APPLY: begin
                if (align_req) begin
                    state_d      = ST_ALIGN;
                    align_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                state_d      = ST_IDLE;
                align_pend_d = align;
            end
            default: begin
                state_d      = ST_IDLE;
                align_pend_d = 1'b0;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            cfg_ready_q  <= 1'b1;
            align_pend_q <= 1'b0;
            cap_ch_q     <= '0;
            cap_period_q <= '0;
            cap_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_ready_q  <= cfg_ready_d;
            align_pend_q <= align_pend_d;
            cap_ch_q     <= cap_ch_d;
            cap_period_q <= cap_period_d;
            cap_en_q     <= cap_en_d;
        end
    end

    assign cfg_ready = cfg_ready_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] period_q, period_d;
            logic [CNT_W-1:0] count_q, count_d;
            logic             en_q, en_d;
            logic             tick_q, tick_d;
            logic             sq_q, sq_d;
            logic             sel;

            assign sel = (state_q == ST_APPLY) && (cap_ch_q == CH_W'(gi));

            always_comb begin
                period_d = period_q;
                en_d     = en_q;
                count_d  = count_q;
                tick_d   = 1'b0;
                sq_d     = sq_q;
                if (state_q == ST_ALIGN) begin
                    count_d = '0;
                    sq_d    = 1'b0;
                end else if (sel) begin
                    period_d = cap_period_q;
                    en_d     = cap_en_q;
                    count_d  = '0;
                    if (!cap_en_q) begin
                        sq_d = 1'b0;
                    end
                end else if (en_q) begin
                    // count never exceeds period: a period change always restarts the count
                    if (count_q == period_q) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        sq_d    = ~sq_q;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    count_d = '0;
                end
            end

            always_ff @(posedge CLOCK) begin
                if (!RESETN) begin
                    period_q <= DEF_PERIOD;
                    en_q     <= 1'b0;
                    count_q  <= '0;
                    tick_q   <= 1'b0;
                    sq_q     <= 1'b0;
                end else begin
                    period_q <= period_d;
                    en_q     <= en_d;
                    count_q  <= count_d;
                    tick_q   <= tick_d;
                    sq_q     <= sq_d;
                end
            end

            assign tick[gi] = tick_q;
            assign sq[gi]   = sq_q;
        end
    endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: hand-computed tick/sq/cfg_ready values cycle by cycle.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 25;

    logic             CLOCK = 1'b0;
    logic             RESETN = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_enable = 1'b0;
    logic             align = 1'b0;
    logic             cfg_ready;
    logic [3:0]       tick;
    logic [3:0]       sq;

    int n_total = 0;
    int n_bad   = 0;

    tick_scheduler #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_PERIOD(24999999)
    ) dut (
        .CLOCK(CLOCK),
        .RESETN(RESETN),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_enable(cfg_enable),
        .align(align),
        .tick(tick),
        .sq(sq)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Present one configuration on the transfer edge; the caller steps through APPLY.
    task automatic xfer(input logic [1:0] ch, input int p, input logic en, input logic al);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = CNT_W'(p);
        cfg_enable = en;
        align      = al;
        step();
        chk("xfer_ready_low", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        align     = 1'b0;
        $display("cfg ch=%0d period=%0d en=%0d align=%0d", ch, p, en, al);
    endtask

    initial begin
        logic [3:0] et;
        logic [3:0] es;

        // reset and long idle
        RESETN = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_sq", 32'(sq), 0);
        RESETN = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step();
            chk("idle_ready", 32'(cfg_ready), 1);
            chk("idle_tick", 32'(tick), 0);
            chk("idle_sq", 32'(sq), 0);
        end
        $display("idle 1000 cycles done");

        // ch0 P=3 enabled
        xfer(2'd0, 3, 1'b1, 1'b0);
        step();
        chk("t2_apply_ready", 32'(cfg_ready), 1);
        chk("t2_apply_tick", 32'(tick), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t2_tick0", 32'(tick[0]), 32'(k % 4 == 0));
            chk("t2_sq0", 32'(sq[0]), 32'((k / 4) % 2));
            chk("t2_tick_hi", 32'(tick[3:1]), 0);
        end

        // ch1 P=0: continuous tick, then disable
        xfer(2'd1, 0, 1'b1, 1'b0);
        step();
        chk("t3_apply_tick1", 32'(tick[1]), 0);
        chk("t3_apply_sq1", 32'(sq[1]), 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t3_tick1", 32'(tick[1]), 1);
            chk("t3_sq1", 32'(sq[1]), 32'(k % 2));
        end
        xfer(2'd1, 0, 1'b0, 1'b0);
        chk("t3_xfer_tick1", 32'(tick[1]), 1);
        step();
        chk("t3_dis_tick1", 32'(tick[1]), 0);
        chk("t3_dis_sq1", 32'(sq[1]), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_off_tick1", 32'(tick[1]), 0);
            chk("t3_off_sq1", 32'(sq[1]), 0);
        end

        // ch0 P=4 and ch2 P=9 out of phase, then align
        xfer(2'd0, 4, 1'b1, 1'b0);
        step();
        repeat (3) step();
        xfer(2'd2, 9, 1'b1, 1'b0);
        step();
        repeat (2) step();
        align = 1'b1;
        step();
        chk("t4_align_ready", 32'(cfg_ready), 0);
        align = 1'b0;
        $display("align pulse");
        step();
        chk("t4_aligned_ready", 32'(cfg_ready), 1);
        chk("t4_aligned_tick", 32'(tick), 0);
        chk("t4_aligned_sq", 32'(sq), 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            et = {1'b0, (k % 10 == 0), 1'b0, (k % 5 == 0)};
            es = {1'b0, ((k / 10) % 2 == 1), 1'b0, ((k / 5) % 2 == 1)};
            chk("t4_tick", 32'(tick), 32'(et));
            chk("t4_sq", 32'(sq), 32'(es));
        end

        // cfg_valid and align together: APPLY then ALIGN
        xfer(2'd3, 2, 1'b1, 1'b1);
        step();
        chk("t5_apply_ready", 32'(cfg_ready), 0);
        step();
        chk("t5_align_ready", 32'(cfg_ready), 1);
        chk("t5_align_tick", 32'(tick), 0);
        chk("t5_align_sq", 32'(sq), 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            et = {(k % 3 == 0), (k % 10 == 0), 1'b0, (k % 5 == 0)};
            es = {((k / 3) % 2 == 1), ((k / 10) % 2 == 1), 1'b0, ((k / 5) % 2 == 1)};
            chk("t5_tick", 32'(tick), 32'(et));
            chk("t5_sq", 32'(sq), 32'(es));
        end

        // reset asserted on the APPLY edge
        xfer(2'd1, 5, 1'b1, 1'b0);
        RESETN = 1'b0;
        step();
        chk("t6_rst_ready", 32'(cfg_ready), 1);
        chk("t6_rst_tick", 32'(tick), 0);
        chk("t6_rst_sq", 32'(sq), 0);
        RESETN = 1'b1;
        $display("reset during apply");
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t6_stop_tick", 32'(tick), 0);
            chk("t6_stop_sq", 32'(sq), 0);
            chk("t6_stop_ready", 32'(cfg_ready), 1);
        end
        xfer(2'd2, 1, 1'b1, 1'b0);
        step();
        chk("t6_apply_ready", 32'(cfg_ready), 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            et = {1'b0, (k % 2 == 0), 1'b0, 1'b0};
            es = {1'b0, ((k / 2) % 2 == 1), 1'b0, 1'b0};
            chk("t6_tick", 32'(tick), 32'(et));
            chk("t6_sq", 32'(sq), 32'(es));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
